// File: rtl/crc_pkg.sv
// Shared CRC16-USB constants, transmit state encoding and the byte-wide CRC step.
package crc_pkg;

    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC16_XOROUT    = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SEND,
        CRC_LO,
        CRC_HI,
        DONE
    } tx_state_t;

    // Reflected CRC: the data byte is folded in LSB-first, one bit per shift.
    function automatic logic [15:0] crc16_usb_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_frame_tx.sv
// Frame transmitter: reads a payload from byte memory, streams it and appends CRC16-USB (low byte first).
// Optional macro CRC_TX_CORRUPT_EN adds crc_corrupt to flip bit 0 of the transmitted CRC low byte.
module crc_frame_tx
    import crc_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk50m,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [ADDR_W-1:0] tx_base,
    input  logic [LEN_W-1:0]  tx_len,
`ifdef CRC_TX_CORRUPT_EN
    input  logic              crc_corrupt,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [15:0]       crc_out
);

    tx_state_t         state_reg;
    tx_state_t         state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [7:0]        data_reg;
    logic [15:0]       crc_reg;
    logic [15:0]       crc_out_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              corrupt_bit;
    logic              more_bytes;

    // Compare one bit wider so idx+1 cannot wrap at the maximum length.
    assign more_bytes = (({1'b0, idx_reg} + (LEN_W + 1)'(1)) < {1'b0, len_reg});

`ifdef CRC_TX_CORRUPT_EN
    logic corrupt_reg;

    always_ff @(posedge clk50m) begin
        if (rst) begin
            corrupt_reg <= 1'b0;
        end else if (state_reg == IDLE && tx_start) begin
            corrupt_reg <= crc_corrupt;
        end
    end

    assign corrupt_bit = corrupt_reg;
`else
    assign corrupt_bit = 1'b0;
`endif

    always_ff @(posedge clk50m) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tx_start) state_next = (tx_len != '0) ? READ : CRC_LO;
            READ:    state_next = LOAD;
            LOAD:    state_next = SEND;
            SEND:    if (tx_ready) state_next = more_bytes ? READ : CRC_LO;
            CRC_LO:  if (tx_ready) state_next = CRC_HI;
            CRC_HI:  if (tx_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: frame parameters, read address, payload byte and running CRC.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            base_reg     <= '0;
            len_reg      <= '0;
            idx_reg      <= '0;
            data_reg     <= 8'h00;
            crc_reg      <= CRC16_INIT;
            crc_out_reg  <= 16'h0000;
            mem_addr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tx_start) begin
                        base_reg <= tx_base;
                        len_reg  <= tx_len;
                        idx_reg  <= '0;
                        crc_reg  <= CRC16_INIT;
                        if (tx_len == '0) begin
                            crc_out_reg <= CRC16_INIT ^ CRC16_XOROUT;
                        end
                    end
                end
                READ: begin
                    mem_addr_reg <= base_reg + ADDR_W'(idx_reg);
                end
                LOAD: begin
                    data_reg <= mem_data;
                    crc_reg  <= crc16_usb_byte(crc_reg, mem_data);
                end
                SEND: begin
                    if (tx_ready) begin
                        idx_reg <= idx_reg + LEN_W'(1);
                        // Latch on entry to CRC_LO so crc_out is valid alongside the first CRC byte.
                        if (!more_bytes) begin
                            crc_out_reg <= crc_reg ^ CRC16_XOROUT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_busy  = 1'b1;
        tx_done  = 1'b0;
        tx_data  = 8'h00;
        case (state_reg)
            IDLE: tx_busy = 1'b0;
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = data_reg;
            end
            CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = crc_out_reg[7:0] ^ {7'b0000000, corrupt_bit};
            end
            CRC_HI: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = crc_out_reg[15:8];
            end
            DONE: begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign mem_addr = mem_addr_reg;
    assign crc_out  = crc_out_reg;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx: reference CRC stream, zero length, back-pressure, address wrap, reset abort.
module tb_crc_frame_tx;

    logic        clk50m = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [9:0]  tx_base;
    logic [9:0]  tx_len;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        tx_busy;
    logic        tx_done;
    logic [15:0] crc_out;
`ifdef CRC_TX_CORRUPT_EN
    logic        crc_corrupt;
`endif

    logic [7:0]  mem [0:1023];
    logic [7:0]  got_data [$];
    logic        got_last [$];
    logic [9:0]  got_addr [$];
    int          done_count;
    int          checks;
    int          failures;

    always #10 clk50m = ~clk50m;

    assign mem_data = mem[mem_addr];

    crc_frame_tx #(.ADDR_W(10), .LEN_W(10)) dut (
        .clk50m   (clk50m),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_base  (tx_base),
        .tx_len   (tx_len),
`ifdef CRC_TX_CORRUPT_EN
        .crc_corrupt (crc_corrupt),
`endif
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .crc_out  (crc_out)
    );

    // Starts a frame and collects every accepted byte; optionally stalls or resets on byte 0x34.
    task automatic run_frame(input logic [9:0] base, input logic [9:0] len,
                             input bit do_stall, input bit rst_at_stall, input bit mid_start);
        int         stall_left;
        bit         stalled;
        bit         seen_done;
        int         post;
        logic [9:0] saved_addr;
        got_data.delete();
        got_last.delete();
        got_addr.delete();
        done_count = 0;
        stall_left = 0;
        stalled    = 0;
        seen_done  = 0;
        post       = 0;
        saved_addr = '0;
        tx_base  = base;
        tx_len   = len;
        tx_start = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk50m); #1;
        tx_start = 1'b0;
        tx_base  = 10'h155;
        tx_len   = 10'd3;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (tx_done) begin
                done_count++;
                seen_done = 1;
                checks++;
                if (tx_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_done: tx_busy=%0b expected 0", tx_busy);
                end
            end
            tx_start = mid_start && (cyc == 7);
            if (do_stall && !stalled && tx_valid && tx_data == 8'h34) begin
                stalled = 1;
                if (rst_at_stall) begin
                    rst = 1'b1;
                    @(posedge clk50m); #1;
                    rst = 1'b0;
                    checks += 5;
                    if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0b expected 0", tx_valid); end
                    if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b expected 0", tx_busy); end
                    if (mem_addr !== 10'h000) begin failures++; $display("FAIL rst_addr: got %03h expected 000", mem_addr); end
                    if (crc_out !== 16'h0000) begin failures++; $display("FAIL rst_crc: got %04h expected 0000", crc_out); end
                    if (tx_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b expected 0", tx_done); end
                    for (int k = 0; k < 4; k++) begin
                        @(posedge clk50m); #1;
                        checks++;
                        if (tx_done !== 1'b0 || tx_valid !== 1'b0) begin
                            failures++;
                            $display("FAIL rst_idle: done=%0b valid=%0b expected 0 0", tx_done, tx_valid);
                        end
                    end
                    return;
                end
                stall_left = 5;
                saved_addr = mem_addr;
            end
            if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== 8'h34 || mem_addr !== saved_addr) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b data=%02h addr=%03h expected 1 34 %03h",
                             tx_valid, tx_data, mem_addr, saved_addr);
                end
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                got_data.push_back(tx_data);
                got_last.push_back(tx_last);
                got_addr.push_back(mem_addr);
                $display("tx byte=%02h last=%0b addr=%03h", tx_data, tx_last, mem_addr);
            end
            if (seen_done) begin
                post++;
                if (post > 3) break;
            end
            @(posedge clk50m); #1;
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL frame_timeout: tx_done not seen, got %0d bytes expected completion", got_data.size());
        end
        tx_start = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_base  = '0;
        tx_len   = '0;
        tx_ready = 1'b0;
`ifdef CRC_TX_CORRUPT_EN
        crc_corrupt = 1'b0;
`endif
        repeat (3) @(posedge clk50m);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_last !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0 ||
            tx_data !== 8'h00 || crc_out !== 16'h0000 || mem_addr !== 10'h000) begin
            failures++;
            $display("FAIL reset_state: valid=%0b last=%0b busy=%0b done=%0b data=%02h crc=%04h addr=%03h expected all 0",
                     tx_valid, tx_last, tx_busy, tx_done, tx_data, crc_out, mem_addr);
        end
        rst = 1'b0;
        @(posedge clk50m); #1;
    endtask

    task automatic test_basic;
        logic [7:0] exp [0:10];
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        run_frame(10'h000, 10'd9, 0, 0, 0);
        checks += 3;
        if (got_data.size() != 11) begin failures++; $display("FAIL basic_count: got %0d expected 11", got_data.size()); end
        if (crc_out !== 16'hB4C8) begin failures++; $display("FAIL basic_crc: got %04h expected B4C8", crc_out); end
        if (done_count != 1) begin failures++; $display("FAIL basic_done: got %0d pulses expected 1", done_count); end
        for (int i = 0; i < 11 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp[i] || got_last[i] !== (i == 10)) begin
                failures++;
                $display("FAIL basic_byte%0d: got %02h last=%0b expected %02h last=%0b", i, got_data[i], got_last[i], exp[i], i == 10);
            end
        end
    endtask

    task automatic test_zero_len;
        logic [9:0] addr_before;
        addr_before = mem_addr;
        run_frame(10'h200, 10'd0, 0, 0, 0);
        checks += 4;
        if (got_data.size() != 2) begin failures++; $display("FAIL zero_count: got %0d expected 2", got_data.size()); end
        else if (got_data[0] !== 8'h00 || got_data[1] !== 8'h00 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
            failures++;
            $display("FAIL zero_bytes: got %02h %02h last %0b%0b expected 00 00 last 01", got_data[0], got_data[1], got_last[0], got_last[1]);
        end
        if (crc_out !== 16'h0000) begin failures++; $display("FAIL zero_crc: got %04h expected 0000", crc_out); end
        if (mem_addr !== addr_before) begin failures++; $display("FAIL zero_addr: got %03h expected %03h", mem_addr, addr_before); end
        if (done_count != 1) begin failures++; $display("FAIL zero_done: got %0d expected 1", done_count); end
    endtask

    task automatic test_stall;
        logic [7:0] exp [0:10];
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        run_frame(10'h000, 10'd9, 1, 0, 0);
        checks += 2;
        if (got_data.size() != 11) begin failures++; $display("FAIL stall_count: got %0d expected 11", got_data.size()); end
        if (crc_out !== 16'hB4C8) begin failures++; $display("FAIL stall_crc: got %04h expected B4C8", crc_out); end
        for (int i = 0; i < 11 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp[i]) begin
                failures++;
                $display("FAIL stall_byte%0d: got %02h expected %02h", i, got_data[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [7:0]  pay [0:3];
        logic [9:0]  addrs [0:3];
        logic [15:0] crc;
        logic [7:0]  b;
        pay   = '{8'hA5, 8'h5A, 8'h31, 8'h32};
        addrs = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        crc = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            b = pay[k];
            for (int j = 0; j < 8; j++) begin
                if (crc[0] ^ b[0]) crc = (crc >> 1) ^ 16'hA001;
                else               crc = crc >> 1;
                b = b >> 1;
            end
        end
        crc = crc ^ 16'hFFFF;
        run_frame(10'h3FE, 10'd4, 0, 0, 1);
        checks += 3;
        if (got_data.size() != 6) begin failures++; $display("FAIL wrap_count: got %0d expected 6", got_data.size()); end
        if (crc_out !== crc) begin failures++; $display("FAIL wrap_crc: got %04h expected %04h", crc_out, crc); end
        if (done_count != 1) begin failures++; $display("FAIL wrap_done: got %0d expected 1", done_count); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== pay[i] || got_addr[i] !== addrs[i]) begin
                failures++;
                $display("FAIL wrap_byte%0d: got %02h@%03h expected %02h@%03h", i, got_data[i], got_addr[i], pay[i], addrs[i]);
            end
        end
        if (got_data.size() == 6) begin
            checks++;
            if (got_data[4] !== crc[7:0] || got_data[5] !== crc[15:8]) begin
                failures++;
                $display("FAIL wrap_crc_bytes: got %02h %02h expected %02h %02h", got_data[4], got_data[5], crc[7:0], crc[15:8]);
            end
        end
    endtask

    task automatic test_reset_mid;
        run_frame(10'h000, 10'd9, 1, 1, 0);
        checks++;
        if (got_data.size() != 3) begin failures++; $display("FAIL abort_count: got %0d expected 3", got_data.size()); end
        run_frame(10'h000, 10'd9, 0, 0, 0);
        checks += 2;
        if (crc_out !== 16'hB4C8) begin failures++; $display("FAIL rerun_crc: got %04h expected B4C8", crc_out); end
        if (got_data.size() != 11) begin failures++; $display("FAIL rerun_count: got %0d expected 11", got_data.size()); end
        else begin
            checks++;
            if (got_data[9] !== 8'hC8 || got_data[10] !== 8'hB4) begin
                failures++;
                $display("FAIL rerun_crc_bytes: got %02h %02h expected C8 B4", got_data[9], got_data[10]);
            end
        end
    endtask

`ifdef CRC_TX_CORRUPT_EN
    task automatic test_corrupt;
        crc_corrupt = 1'b1;
        run_frame(10'h000, 10'd9, 0, 0, 0);
        crc_corrupt = 1'b0;
        checks += 2;
        if (crc_out !== 16'hB4C8) begin failures++; $display("FAIL corrupt_crc_out: got %04h expected B4C8", crc_out); end
        if (got_data.size() != 11) begin failures++; $display("FAIL corrupt_count: got %0d expected 11", got_data.size()); end
        else begin
            checks++;
            if (got_data[9] !== 8'hC9 || got_data[10] !== 8'hB4) begin
                failures++;
                $display("FAIL corrupt_bytes: got %02h %02h expected C9 B4", got_data[9], got_data[10]);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        mem[10'h3FE] = 8'hA5;
        mem[10'h3FF] = 8'h5A;
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_wrap();
        test_reset_mid();
`ifdef CRC_TX_CORRUPT_EN
        test_corrupt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
